// File: rtl/fetch_ctrl.sv
// Y86-style instruction fetch: pulls an instruction one byte at a time from a byte-wide
// memory, decodes its length and status, presents it downstream, then waits for the next PC.
module fetch_ctrl #(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int          IMEM_SIZE   = 1024,
    parameter int          MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic [7:0]  imem_rdata,
    input  logic        imem_ack,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [79:0] instr_out,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  ilen,
    output logic [63:0] pc_out,
    output logic [63:0] valP,
    output logic [2:0]  stat,
    input  logic        pc_upd_valid,
    input  logic [63:0] pc_upd,
    output logic        busy
);
    typedef enum logic [2:0] {FETCH0, FETCHN, PRESENT, WAIT_PC, HALT, ERR} state_e;

    localparam logic [2:0]  S_AOK = 3'd1, S_HLT = 3'd2, S_ADR = 3'd3, S_INS = 3'd4;
    localparam int          TW    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [63:0] LIMIT = 64'(IMEM_SIZE);

    state_e        state_q, state_d;
    logic [63:0]   pc_q, pc_d, valp_q, valp_d;
    logic [79:0]   instr_q, instr_d;
    logic [3:0]    icode_q, icode_d, ifun_q, ifun_d, ilen_q, ilen_d, idx_q, idx_d;
    logic [2:0]    stat_q, stat_d;
    logic [TW-1:0] to_q, to_d;

    logic [63:0] addr;
    logic        fetching, addr_ok, req, hit, timed_out;
    logic [3:0]  len0;

    function automatic logic [3:0] ilen_of(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:       return 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: return 4'd2;
            4'h7, 4'h8:             return 4'd9;
            4'h3, 4'h4, 4'h5:       return 4'd10;
            default:                return 4'd1;
        endcase
    endfunction

    // Request is combinational so zero-wait memory can ack in the same cycle; gating with
    // rst_n drops it the moment reset is asserted, abandoning any in-flight request.
    assign fetching  = (state_q == FETCH0) || (state_q == FETCHN);
    assign addr      = pc_q + {60'd0, idx_q};
    assign addr_ok   = addr < LIMIT;
    assign req       = rst_n && fetching && addr_ok;
    assign hit       = req && imem_ack;
    assign timed_out = to_q == TW'(MEM_TIMEOUT - 1);
    assign len0      = ilen_of(imem_rdata[7:4]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH0;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            icode_q <= '0;
            ifun_q  <= '0;
            ilen_q  <= '0;
            valp_q  <= '0;
            stat_q  <= S_AOK;
            idx_q   <= '0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            icode_q <= icode_d;
            ifun_q  <= ifun_d;
            ilen_q  <= ilen_d;
            valp_q  <= valp_d;
            stat_q  <= stat_d;
            idx_q   <= idx_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        icode_d = icode_q;
        ifun_d  = ifun_q;
        ilen_d  = ilen_q;
        valp_d  = valp_q;
        stat_d  = stat_q;
        idx_d   = idx_q;
        to_d    = to_q;
        case (state_q)
            FETCH0, FETCHN: begin
                if (!addr_ok || (!hit && timed_out)) begin
                    state_d = PRESENT;
                    stat_d  = S_ADR;
                    valp_d  = pc_q;
                end else if (hit) begin
                    to_d = '0;
                    if (state_q == FETCH0) begin
                        instr_d[7:0] = imem_rdata;
                        icode_d      = imem_rdata[7:4];
                        ifun_d       = imem_rdata[3:0];
                        ilen_d       = len0;
                        if (imem_rdata[7:4] >= 4'hC) begin
                            state_d = PRESENT;
                            stat_d  = S_INS;
                            valp_d  = pc_q;
                        end else if (len0 == 4'd1) begin
                            state_d = PRESENT;
                            stat_d  = (imem_rdata[7:4] == 4'h0) ? S_HLT : S_AOK;
                            valp_d  = (imem_rdata[7:4] == 4'h0) ? pc_q : pc_q + 64'd1;
                        end else begin
                            state_d = FETCHN;
                            idx_d   = 4'd1;
                        end
                    end else begin
                        for (int k = 1; k < 10; k++)
                            if (idx_q == 4'(k)) instr_d[8*k +: 8] = imem_rdata;
                        if (idx_q == ilen_q - 4'd1) begin
                            state_d = PRESENT;
                            stat_d  = S_AOK;
                            valp_d  = pc_q + {60'd0, ilen_q};
                        end else begin
                            idx_d = idx_q + 4'd1;
                        end
                    end
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    case (stat_q)
                        S_AOK:   state_d = WAIT_PC;
                        S_HLT:   state_d = HALT;
                        default: state_d = ERR;
                    endcase
                end
            end
            WAIT_PC: begin
                if (pc_upd_valid) begin
                    state_d = FETCH0;
                    pc_d    = pc_upd;
                    instr_d = '0;
                    icode_d = '0;
                    ifun_d  = '0;
                    ilen_d  = '0;
                    idx_d   = '0;
                    to_d    = '0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        imem_req  = req;
        imem_addr = addr;
        out_valid = state_q == PRESENT;
        busy      = !((state_q == WAIT_PC) || (state_q == HALT) || (state_q == ERR));
        instr_out = instr_q;
        icode     = icode_q;
        ifun      = ifun_q;
        ilen      = ilen_q;
        pc_out    = pc_q;
        valP      = valp_q;
        stat      = stat_q;
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: table of single-instruction fetches plus hand sequences
// for reset, wait states, timeout and output hold under backpressure.
module tb_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, imem_req, imem_ack, out_valid, out_ready, pc_upd_valid, busy;
    logic [63:0] imem_addr, pc_out, valP, pc_upd;
    logic [7:0]  imem_rdata;
    logic [79:0] instr_out;
    logic [3:0]  icode, ifun, ilen;
    logic [2:0]  stat;

    fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack), .out_valid(out_valid),
        .out_ready(out_ready), .instr_out(instr_out), .icode(icode), .ifun(ifun),
        .ilen(ilen), .pc_out(pc_out), .valP(valP), .stat(stat),
        .pc_upd_valid(pc_upd_valid), .pc_upd(pc_upd), .busy(busy)
    );

    always #5 clk = ~clk;

    // Byte memory: ack after ack_lat waiting cycles; force_ack injects stray acks.
    logic [7:0] mem [1024];
    int ack_lat = 0, wait_cnt = 0;
    logic force_ack = 1'b0;
    assign imem_rdata = (imem_addr < 64'd1024) ? mem[imem_addr[9:0]] : 8'h00;
    assign imem_ack   = force_ack | (imem_req && (wait_cnt >= ack_lat));
    always @(posedge clk) wait_cnt <= (imem_req && !imem_ack) ? wait_cnt + 1 : 0;

    int req_total = 0, ack_total = 0, bad_addr = 0, unstable = 0;
    logic pend = 1'b0;
    logic [63:0] paddr = '0;
    always @(negedge clk) begin
        if (imem_req) req_total++;
        if (imem_req && imem_ack) ack_total++;
        if (imem_req && imem_addr >= 64'd1024) bad_addr++;
        if (imem_req && pend && imem_addr != paddr) unstable++;
        pend  = imem_req && !imem_ack;
        paddr = imem_addr;
    end

    int n_chk = 0, n_bad = 0;
    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_valid(input int lim, output int n);
        n = 0;
        do begin tick(); n++; end while (!out_valid && n < lim);
    endtask

    task automatic xfer();
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic go(input logic [63:0] pc);
        pc_upd = pc; pc_upd_valid = 1'b1; tick(); pc_upd_valid = 1'b0;
    endtask

    task automatic clear_mem();
        for (int a = 0; a < 1024; a++) mem[a] = 8'h00;
    endtask

    // Reset, fetch the nop at address 0 and hand it off, leaving the DUT in WAIT_PC.
    task automatic boot();
        int n;
        rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
        wait_valid(40, n);
        chk("boot_valid", out_valid, 1);
        xfer();
    endtask

    typedef struct {
        logic [63:0] pc;
        logic [79:0] bytes;
        logic [3:0]  icode, ifun, ilen;
        logic [63:0] valp;
        logic [2:0]  stat;
        int          cyc, nreq;
        logic [79:0] instr;
    } vec_t;
    vec_t vt[10];

    task automatic run_vec(input int i);
        vec_t v;
        int n, r0;
        v = vt[i];
        clear_mem();
        mem[0] = 8'h10;
        for (int k = 0; k < 10; k++)
            if (v.pc + 64'(k) < 64'd1024) mem[v.pc[9:0] + 10'(k)] = v.bytes[8*k +: 8];
        ack_lat = 0;
        boot();
        go(v.pc);
        chk($sformatf("v%0d first_req", i), imem_req, 1);
        chk($sformatf("v%0d first_addr", i), imem_addr, v.pc);
        r0 = ack_total;
        wait_valid(40, n);
        chk($sformatf("v%0d cycles", i), n, v.cyc);
        chk($sformatf("v%0d nreq", i), ack_total - r0, v.nreq);
        chk($sformatf("v%0d icode", i), icode, v.icode);
        chk($sformatf("v%0d ifun", i), ifun, v.ifun);
        chk($sformatf("v%0d ilen", i), ilen, v.ilen);
        chk($sformatf("v%0d valP", i), valP, v.valp);
        chk($sformatf("v%0d stat", i), stat, v.stat);
        chk($sformatf("v%0d instr", i), instr_out, v.instr);
        chk($sformatf("v%0d pc_out", i), pc_out, v.pc);
        xfer();
        r0 = req_total;
        for (int c = 0; c < 20; c++) begin
            if (c == 3 && v.stat != 3'd1) begin pc_upd = 64'd0; pc_upd_valid = 1'b1; end
            tick();
            pc_upd_valid = 1'b0;
        end
        chk($sformatf("v%0d idle_reqs", i), req_total - r0, 0);
        chk($sformatf("v%0d idle_busy", i), busy, 0);
        chk($sformatf("v%0d idle_valid", i), out_valid, 0);
        chk($sformatf("v%0d idle_stat", i), stat, v.stat);
        chk($sformatf("v%0d idle_pc", i), pc_out, v.pc);
    endtask

    initial begin
        int n;
        logic [79:0] irm;
        //      pc      bytes (byte k at [8k+7:8k])       ic    if    len    valP   st  cyc nrq instr
        vt[0] = '{64'd16,   80'h10,                    4'h1, 4'h0, 4'd1,  64'd17,   3'd1, 1, 1, 80'h10};
        vt[1] = '{64'd16,   80'h0807060504030201F230,  4'h3, 4'h0, 4'd10, 64'd26,   3'd1, 10, 10, 80'h0807060504030201F230};
        vt[2] = '{64'd16,   80'h992361,                4'h6, 4'h1, 4'd2,  64'd18,   3'd1, 2, 2, 80'h2361};
        vt[3] = '{64'd16,   80'h5500,                  4'h0, 4'h0, 4'd1,  64'd16,   3'd2, 1, 1, 80'h0};
        vt[4] = '{64'd16,   80'h55C0,                  4'hC, 4'h0, 4'd1,  64'd16,   3'd4, 1, 1, 80'hC0};
        vt[5] = '{64'd1023, 80'h70,                    4'h7, 4'h0, 4'd9,  64'd1023, 3'd3, 2, 1, 80'h70};
        vt[6] = '{64'd1014, 80'h99887766554433221180,  4'h8, 4'h0, 4'd9,  64'd1023, 3'd1, 9, 9, 80'h00887766554433221180};
        vt[7] = '{64'd16,   80'h2FA0,                  4'hA, 4'h0, 4'd2,  64'd18,   3'd1, 2, 2, 80'h2FA0};
        vt[8] = '{64'd16,   80'h90,                    4'h9, 4'h0, 4'd1,  64'd17,   3'd1, 1, 1, 80'h90};
        vt[9] = '{64'd100,  80'h00000000000000400150,  4'h5, 4'h0, 4'd10, 64'd110,  3'd1, 10, 10, 80'h00000000000000400150};

        rst_n = 1'b0; out_ready = 1'b0; pc_upd_valid = 1'b0; pc_upd = '0;

        // Reset state, first request, then reset 4 bytes into a 10-byte fetch.
        clear_mem();
        irm = 80'h0807060504030201F230;
        for (int k = 0; k < 10; k++) mem[k] = irm[8*k +: 8];
        tick(); tick();
        chk("rst_req", imem_req, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_instr", instr_out, 0);
        chk("rst_icode", {icode, ifun, ilen}, 0);
        chk("rst_valP", valP, 0);
        chk("rst_stat", stat, 1);
        chk("rst_pc", pc_out, 0);
        rst_n = 1'b1; #1;
        chk("rel_req", imem_req, 1);
        chk("rel_addr", imem_addr, 0);
        repeat (4) tick();
        chk("mid_addr", imem_addr, 4);
        rst_n = 1'b0; tick();
        chk("midrst_req", imem_req, 0);
        chk("midrst_instr", instr_out, 0);
        chk("midrst_valid", out_valid, 0);
        rst_n = 1'b1; #1;
        chk("refetch_addr", imem_addr, 0);
        wait_valid(40, n);
        chk("refetch_cycles", n, 10);
        chk("refetch_instr", instr_out, irm);
        chk("refetch_byte1", instr_out[15:8], 8'hF2);
        chk("refetch_valP", valP, 10);
        xfer();
        force_ack = 1'b1; repeat (3) tick(); force_ack = 1'b0;
        chk("stray_ack_busy", busy, 0);
        chk("stray_ack_valid", out_valid, 0);

        for (int i = 0; i < 10; i++) run_vec(i);

        // Three wait states per byte: req and addr must hold until each ack.
        clear_mem(); mem[0] = 8'h10; mem[16] = 8'h61; mem[17] = 8'h23;
        ack_lat = 0; boot();
        ack_lat = 3; go(64'd16);
        wait_valid(60, n);
        chk("ws_cycles", n, 8);
        chk("ws_instr", instr_out, 80'h2361);
        chk("ws_valP", valP, 18);
        chk("ws_stat", stat, 1);
        xfer();

        // Ack never arrives: timeout gives ADR, then outputs hold under backpressure.
        clear_mem(); mem[0] = 8'h10;
        ack_lat = 0; boot();
        ack_lat = 1000; go(64'd16);
        wait_valid(60, n);
        chk("to_cycles", n, 16);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("to_hold%0d_valid", c), out_valid, 1);
            chk($sformatf("to_hold%0d_stat", c), stat, 3);
            chk($sformatf("to_hold%0d_valP", c), valP, 16);
            chk($sformatf("to_hold%0d_pc", c), pc_out, 16);
            tick();
        end
        xfer();
        chk("to_err_busy", busy, 0);
        chk("to_err_stat", stat, 3);

        chk("bad_addr_reqs", bad_addr, 0);
        chk("unstable_addr", unstable, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end
endmodule
